// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolve unit: funct3 codes, FSM encoding, datapath width.
// Imported by branch_cond_eval and branch_resolve_unit.
package riscv_branch_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef struct packed {
        logic taken;
        logic brun_en;
        logic illegal;
    } cond_res_t;

    // Instruction fetch requires 4-byte alignment, so either low bit set is a fault.
    function automatic logic target_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational branch condition evaluation: funct3 plus comparator flags
// give taken / comparator mode / illegal-encoding indications.
module branch_cond_eval
    import riscv_branch_pkg::*;
(
    input  logic       is_branch,
    input  logic [2:0] funct3,
    input  logic       breq_flag,
    input  logic       brlt_flag,
    input  logic       bge_flag,
    output logic       taken,
    output logic       brun_en,
    output logic       illegal
);

    cond_res_t res_s;

    // Decode funct3 against the comparator flags.
    always_comb begin
        res_s         = '0;
        res_s.brun_en = is_branch & funct3[1];
        case (funct3)
            F3_BEQ:  res_s.taken = is_branch & breq_flag;
            F3_BNE:  res_s.taken = is_branch & ~breq_flag;
            F3_BLT:  res_s.taken = is_branch & brlt_flag;
            F3_BLTU: res_s.taken = is_branch & brlt_flag;
            F3_BGE:  res_s.taken = is_branch & (breq_flag | bge_flag);
            F3_BGEU: res_s.taken = is_branch & (breq_flag | bge_flag);
            default: begin
                // 010 / 011 are unused branch encodings
                res_s.taken   = 1'b0;
                res_s.illegal = is_branch;
            end
        endcase
    end

    assign taken   = res_s.taken;
    assign brun_en = res_s.brun_en;
    assign illegal = res_s.illegal;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: target generation, held redirect handshake and pipeline flush.
// Optional BRANCH_STATS_EN adds saturating stat_branches / stat_taken counters.
module branch_resolve_unit
    import riscv_branch_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            breq_flag,
    input  logic            brlt_flag,
    input  logic            bge_flag,
    output logic            brun_en,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            stall_ex,
    output logic            misalign_exc,
    output logic            illegal_br
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_taken
`endif
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic             stall_ex_q, stall_ex_d;
    logic             flush_q, flush_d;
    logic             misalign_q, misalign_d;
    logic             illegal_q, illegal_d;

    logic             sel_jalr_s, sel_jal_s, sel_br_s;
    logic [XLEN-1:0]  base_s, sum_s, target_s;
    logic             cond_taken_s, cond_illegal_s;
    logic             taken_s, misaligned_s, accept_s, handshake_s;

    branch_cond_eval u_cond (
        .is_branch (ex_is_branch),
        .funct3    (ex_funct3),
        .breq_flag (breq_flag),
        .brlt_flag (brlt_flag),
        .bge_flag  (bge_flag),
        .taken     (cond_taken_s),
        .brun_en   (brun_en),
        .illegal   (cond_illegal_s)
    );

    // Type priority (jalr > jal > branch) and target adder.
    always_comb begin
        sel_jalr_s = ex_is_jalr;
        sel_jal_s  = ex_is_jal & ~ex_is_jalr;
        sel_br_s   = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;
        base_s     = sel_jalr_s ? ex_rs1 : ex_pc;
        sum_s      = base_s + ex_imm;
        target_s   = sum_s;
        if (sel_jalr_s) begin
            target_s[0] = 1'b0;
        end else begin
            target_s[0] = sum_s[0];
        end
        taken_s      = sel_jalr_s | sel_jal_s | (sel_br_s & cond_taken_s);
        misaligned_s = target_misaligned(target_s[1:0]);
        accept_s     = ex_valid & (state_q == ST_IDLE);
    end

    // Redirect FSM and flush counter next-state.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        redirect_pc_d = redirect_pc_q;
        misalign_d    = 1'b0;
        illegal_d     = 1'b0;
        handshake_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                misalign_d = accept_s & taken_s & misaligned_s;
                illegal_d  = accept_s & sel_br_s & cond_illegal_s;
                if (accept_s & taken_s & ~misaligned_s) begin
                    state_d       = ST_REQ;
                    redirect_pc_d = target_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (redirect_ready) begin
                    state_d     = ST_FLUSH;
                    cnt_d       = CNT_W'(FLUSH_CYCLES);
                    handshake_s = 1'b1;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Outputs are registered from the next state so they are glitch-free.
        redirect_valid_d = (state_d == ST_REQ);
        stall_ex_d       = (state_d == ST_REQ);
        flush_d          = (state_d == ST_FLUSH);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            stall_ex_q       <= 1'b0;
            flush_q          <= 1'b0;
            misalign_q       <= 1'b0;
            illegal_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_valid_q <= redirect_valid_d;
            stall_ex_q       <= stall_ex_d;
            flush_q          <= flush_d;
            misalign_q       <= misalign_d;
            illegal_q        <= illegal_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign stall_ex       = stall_ex_q;
    assign flush_if_id    = flush_q;
    assign flush_id_ex    = flush_q;
    assign misalign_exc   = misalign_q;
    assign illegal_br     = illegal_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_taken_q, stat_taken_d;

    // Saturating event counters.
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_taken_d    = stat_taken_q;
        if (accept_s & sel_br_s & (stat_branches_q != 32'hFFFF_FFFF)) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end else begin
            stat_branches_d = stat_branches_q;
        end
        if (handshake_s & (stat_taken_q != 32'hFFFF_FFFF)) begin
            stat_taken_d = stat_taken_q + 32'd1;
        end else begin
            stat_taken_d = stat_taken_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q <= 32'd0;
            stat_taken_q    <= 32'd0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_taken_q    <= stat_taken_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_taken    = stat_taken_q;
`else
    logic unused_handshake_s;
    assign unused_handshake_s = handshake_s;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected redirect/exception events are queued at issue
// time and a negedge monitor pops and compares them; flush/stall timing is checked inline.
module tb_branch_resolve_unit;

    localparam int XLEN = 32;
    localparam int FLUSH_CYCLES = 2;
    localparam int EV_REDIR = 0;
    localparam int EV_MISAL = 1;
    localparam int EV_ILL   = 2;

    typedef struct {
        int          kind;
        logic [31:0] pc;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1;
    logic            breq_flag, brlt_flag, bge_flag;
    logic            brun_en, redirect_valid, redirect_ready;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_if_id, flush_id_ex, stall_ex, misalign_exc, illegal_br;
`ifdef BRANCH_STATS_EN
    logic [31:0]     stat_branches, stat_taken;
`endif

    int checks   = 0;
    int failures = 0;
    ev_t exp_q[$];

    branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_funct3      (ex_funct3),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .breq_flag      (breq_flag),
        .brlt_flag      (brlt_flag),
        .bge_flag       (bge_flag),
        .brun_en        (brun_en),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .stall_ex       (stall_ex),
        .misalign_exc   (misalign_exc),
        .illegal_br     (illegal_br)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches  (stat_branches),
        .stat_taken     (stat_taken)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pop_check(input int kind, input logic [31:0] pc);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind %0d pc 0x%08h, expected nothing", kind, pc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EV_REDIR && e.pc !== pc)) begin
                failures++;
                $display("FAIL event: got kind %0d pc 0x%08h expected kind %0d pc 0x%08h",
                         kind, pc, e.kind, e.pc);
            end
        end
    endtask

    // Monitor: every handshake or exception pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (redirect_valid && redirect_ready) pop_check(EV_REDIR, redirect_pc);
            if (misalign_exc) pop_check(EV_MISAL, 32'h0);
            if (illegal_br) pop_check(EV_ILL, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                         input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic eq, input logic lt, input logic ge);
        ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
        ex_funct3 = f3; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
        breq_flag = eq; brlt_flag = lt; bge_flag = ge;
        #1;
    endtask

    task automatic check_quiet(input string nm);
        chk({nm, "_valid"}, {31'd0, redirect_valid}, 32'd0);
        chk({nm, "_stall"}, {31'd0, stall_ex}, 32'd0);
        chk({nm, "_flush"}, {30'd0, flush_if_id, flush_id_ex}, 32'd0);
    endtask

    // Instruction already driven; expects a redirect to exp_pc after ready_delay cycles of back-pressure.
    task automatic run_taken(input string nm, input logic [31:0] exp_pc, input int ready_delay,
                             input bit junk);
        exp_q.push_back('{EV_REDIR, exp_pc});
        tick();
        if (junk) drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h500, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0);
        else ex_valid = 1'b0;
        for (int i = 0; i < ready_delay; i++) begin
            chk({nm, "_wait_valid"}, {31'd0, redirect_valid}, 32'd1);
            chk({nm, "_wait_pc"}, redirect_pc, exp_pc);
            chk({nm, "_wait_stall"}, {31'd0, stall_ex}, 32'd1);
            chk({nm, "_wait_noflush"}, {31'd0, flush_if_id}, 32'd0);
            tick();
        end
        redirect_ready = 1'b1;
        chk({nm, "_valid"}, {31'd0, redirect_valid}, 32'd1);
        chk({nm, "_stall"}, {31'd0, stall_ex}, 32'd1);
        tick();
        redirect_ready = 1'b0;
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            chk({nm, "_flush"}, {30'd0, flush_if_id, flush_id_ex}, 32'd3);
            chk({nm, "_flush_novalid"}, {31'd0, redirect_valid}, 32'd0);
            tick();
        end
        ex_valid = 1'b0;
        check_quiet({nm, "_end"});
    endtask

    task automatic run_not_taken(input string nm);
        tick();
        ex_valid = 1'b0;
        check_quiet(nm);
    endtask

    task automatic run_exc(input string nm, input int kind);
        exp_q.push_back('{kind, 32'h0});
        tick();
        ex_valid = 1'b0;
        check_quiet(nm);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        redirect_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_quiet("reset");
        chk("reset_pc", redirect_pc, 32'h0);
        chk("reset_exc", {30'd0, misalign_exc, illegal_br}, 32'd0);

        // 1: BEQ taken
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("beq_brun", {31'd0, brun_en}, 32'd0);
        run_taken("beq", 32'h120, 0, 1'b0);

        // 2: signedness and conditions
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 32'h200, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("bltu_brun", {31'd0, brun_en}, 32'd1);
        run_taken("bltu", 32'h240, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b101, 32'h200, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("bge_brun", {31'd0, brun_en}, 32'd0);
        run_not_taken("bge_nt");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 32'h200, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("bne_brun", {31'd0, brun_en}, 32'd0);
        run_not_taken("bne_nt");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b101, 32'h300, 32'hFFFF_FFF8, 32'h0, 1'b1, 1'b0, 1'b0);
        run_taken("bge_eq", 32'h2F8, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 32'h400, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("bgeu_brun", {31'd0, brun_en}, 32'd1);
        run_taken("bgeu", 32'h410, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 32'h400, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1);
        run_not_taken("blt_nt");

        // 3: JALR alignment
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h4, 32'h203, 1'b0, 1'b0, 1'b0);
        run_exc("jalr_misal", EV_MISAL);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h4, 32'h200, 1'b0, 1'b0, 1'b0);
        run_taken("jalr", 32'h204, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h4, 32'h201, 1'b0, 1'b0, 1'b0);
        run_taken("jalr_bit0", 32'h204, 0, 1'b0);

        // 4: back-pressure, with a live instruction that must be ignored
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h1000, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
        run_taken("jal_bp", 32'h1100, 3, 1'b1);

        // 5: illegal encodings, wrap, precedence, ex_valid low, misaligned JAL
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0);
        run_exc("ill_010", EV_ILL);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 32'h100, 32'h20, 32'h0, 1'b1, 1'b1, 1'b1);
        run_exc("ill_011", EV_ILL);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0);
        run_taken("wrap", 32'h10, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 32'h100, 32'h8, 32'h300, 1'b0, 1'b0, 1'b0);
        run_taken("prec_jalr", 32'h308, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h100, 32'h10, 32'h300, 1'b0, 1'b0, 1'b0);
        run_taken("prec_jal", 32'h110, 0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h100, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
        run_not_taken("novalid");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h100, 32'h2, 32'h0, 1'b0, 1'b0, 1'b0);
        run_exc("jal_misal", EV_MISAL);

        // 6: reset during FLUSH
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h40, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back('{EV_REDIR, 32'h80});
        tick();
        ex_valid = 1'b0;
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("rstflush_pre", {31'd0, flush_if_id}, 32'd1);
        rst = 1'b1;
        tick();
        check_quiet("rstflush");
        chk("rstflush_pc", redirect_pc, 32'h0);
        chk("rstflush_exc", {30'd0, misalign_exc, illegal_br}, 32'd0);
        rst = 1'b0;
        tick();
        check_quiet("rstflush_after");

        // 5 branches after reset, 3 taken
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h800, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0);
            run_taken("stat_t", 32'h810, 0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 32'h800, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0);
            run_not_taken("stat_nt");
        end
`ifdef BRANCH_STATS_EN
        chk("stat_branches", stat_branches, 32'd5);
        chk("stat_taken", stat_taken, 32'd3);
`endif
        tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
